alu_result_stage: RTL and testbench

//   Downstream stage of the 4-bit ripple adder/subtractor.
//   - Captures the adder's sum/difference and carry-out together with the operands and mode that produced them.
//   - Derives N/Z/C/V flags and buffers result+flags in a small FIFO.
//   - Presents result+flags to the consumer (register file / display) over a valid/ready handshake.
//   - Counts completed operations.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_flag_gen.sv | 46 ++++
 rtl/alu_result_stage.sv | 121 ++++++++++++
 tb/tb_alu_result_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Package alu_pkg: shared flag bit positions and entry types for the
// ALU result stage.
//   FLAG_N/Z/C/V  bit positions inside alu_flags_t ({N,Z,C,V}).
//   alu_flags_t   4-bit flag vector.
//   alu_entry_t   {result, flags} for the default ALU_W-bit datapath.
// Optional feature macro used by this slice: ALU_SAT_EN (saturating result).
package alu_pkg;

    localparam int ALU_W  = 4;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [3:0] alu_flags_t;

    typedef struct packed {
        logic [ALU_W-1:0] result;
        alu_flags_t       flags;
    } alu_entry_t;

endpackage

// File: rtl/alu_flag_gen.sv
// alu_flag_gen: combinational result/flag derivation for one adder output.
//   a, b     operands as fed to the adder (b un-inverted)
//   m        mode, 0 = add, 1 = subtract
//   s, cout  adder sum/difference and carry-out
//   r        result to store (s, or saturated when ALU_SAT_EN is defined)
//   flags    {N,Z,C,V}
// Macro ALU_SAT_EN: on signed overflow clamp r to the most positive /
// most negative value; N and Z then follow the clamped r.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    input  logic [WIDTH-1:0] s,
    input  logic             cout,
    output logic [WIDTH-1:0] r,
    output alu_flags_t       flags
);

    logic [WIDTH-1:0] b_eff;
    logic             v;

    always_comb begin
        // The adder sees b inverted in subtract mode; overflow is judged on
        // the operand it actually added.
        b_eff = b ^ {WIDTH{m}};
        v     = (a[WIDTH-1] == b_eff[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
        r     = s;
`ifdef ALU_SAT_EN
        // Overflow direction follows the sign of a: a negative a can only
        // overflow downwards.
        if (v) begin
            r = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        flags         = '0;
        flags[FLAG_N] = r[WIDTH-1];
        flags[FLAG_Z] = (r == '0);
        flags[FLAG_C] = cout ^ m;   // carry on add, borrow on subtract
        flags[FLAG_V] = v;
    end

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: captures adder results, derives N/Z/C/V flags, buffers
// result+flags in a DEPTH-entry FIFO and hands them to the consumer over
// valid/ready. Counts accepted operations (saturating).
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     producer handshake; in_ready = FIFO not full
//   in_a, in_b, in_m      operands and mode that produced in_s/in_cout
//   in_s, in_cout         adder sum/difference and carry-out
//   out_valid/out_ready   consumer handshake for the head entry
//   out_result, out_flags head entry; hold the last popped entry when empty
//   op_count              accepted ops since reset, sticks at all-ones
// Macro ALU_SAT_EN (in alu_flag_gen): saturating results on overflow.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_m,
    input  logic [WIDTH-1:0] in_s,
    input  logic             in_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags,
    output logic [CNT_W-1:0] op_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        alu_flags_t       flags;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           new_entry;
    entry_t           head;
    entry_t           last_q, last_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;
    logic             push, pop;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .a     (in_a),
        .b     (in_b),
        .m     (in_m),
        .s     (in_s),
        .cout  (in_cout),
        .r     (new_entry.result),
        .flags (new_entry.flags)
    );

    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // While empty, show the most recently popped entry instead of a stale slot.
    assign head       = out_valid ? mem_q[rd_ptr_q] : last_q;
    assign out_result = head.result;
    assign out_flags  = head.flags;
    assign op_count   = op_count_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        last_d     = last_q;
        op_count_d = op_count_q;

        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            if (op_count_q != '1) begin
                op_count_d = op_count_q + 1'b1;
            end
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            last_d   = mem_q[rd_ptr_q];
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            last_q     <= '0;
            op_count_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            last_q     <= last_d;
            op_count_q <= op_count_d;
        end
    end

    // Storage needs no reset: it is unreachable until written after reset.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             in_m = 1'b0;
    logic [WIDTH-1:0] in_s = '0;
    logic             in_cout = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_flags;
    logic [CNT_W-1:0] op_count;

    int vectors = 0;
    int miscompares = 0;
    int exp_ops = 0;

    alu_result_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_m(in_m), .in_s(in_s), .in_cout(in_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Reference: signed/unsigned arithmetic on the operands -> {r, N, Z, C, V}.
    function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b, input logic m);
        int sa, sb, t;
        logic [3:0] r;
        logic n, z, c, v;
        sa = int'($signed(a));
        sb = int'($signed(b));
        t  = m ? sa - sb : sa + sb;
        v  = (t > 7) || (t < -8);
        c  = m ? (int'(a) < int'(b)) : (int'(a) + int'(b) > 15);
        r  = t[3:0];
`ifdef ALU_SAT_EN
        if (v) r = (t > 7) ? 4'b0111 : 4'b1000;
`endif
        n = r[3];
        z = (r == 4'd0);
        return {r, n, z, c, v};
    endfunction

    // Upstream ripple adder/subtractor.
    task automatic drive_op(input logic [3:0] a, input logic [3:0] b, input logic m);
        logic [4:0] sum;
        in_a = a; in_b = b; in_m = m;
        sum = m ? ({1'b0, a} + {1'b0, ~b} + 5'd1) : ({1'b0, a} + {1'b0, b});
        in_s = sum[3:0];
        in_cout = sum[4];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void count_push();
        if (exp_ops < 255) exp_ops++;
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        vectors++; if (out_result !== 4'h0) begin miscompares++; $display("FAIL reset_out_result got %h want 0", out_result); end
        vectors++; if (out_flags !== 4'h0) begin miscompares++; $display("FAIL reset_out_flags got %h want 0", out_flags); end
        vectors++; if (op_count !== 8'h00) begin miscompares++; $display("FAIL reset_op_count got %h want 0", op_count); end
    endtask

    task automatic test_directed();
        logic [3:0] as [3] = '{4'd7, 4'd5, 4'd3};
        logic [3:0] bs [3] = '{4'd1, 4'd5, 4'd5};
        logic       ms [3] = '{1'b0, 1'b1, 1'b1};
        logic [7:0] e;
        for (int i = 0; i < 3; i++) begin
            drive_op(as[i], bs[i], ms[i]);
            e = model(as[i], bs[i], ms[i]);
            in_valid = 1'b1; out_ready = 1'b0;
            vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL dir%0d_no_comb_path got %b want 0", i, out_valid); end
            tick(); count_push();
            in_valid = 1'b0;
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL dir%0d_latency got %b want 1", i, out_valid); end
            vectors++; if ({out_result, out_flags} !== e) begin miscompares++; $display("FAIL dir%0d_entry got %h want %h", i, {out_result, out_flags}, e); end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL dir%0d_empty got %b want 0", i, out_valid); end
            vectors++; if ({out_result, out_flags} !== e) begin miscompares++; $display("FAIL dir%0d_hold got %h want %h", i, {out_result, out_flags}, e); end
            vectors++; if (op_count !== CNT_W'(exp_ops)) begin miscompares++; $display("FAIL dir%0d_op_count got %0d want %0d", i, op_count, exp_ops); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] e [3];
        logic [3:0] a, b;
        logic       m;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 4'($urandom); b = 4'($urandom); m = 1'($urandom);
            drive_op(a, b, m);
            e[i] = model(a, b, m);
            in_valid = 1'b1;
            tick();
            if (i < 2) count_push();
            vectors++; if (in_ready !== (i == 0)) begin miscompares++; $display("FAIL bp_in_ready%0d got %b want %b", i, in_ready, (i == 0)); end
        end
        in_valid = 1'b0;
        vectors++; if (op_count !== CNT_W'(exp_ops)) begin miscompares++; $display("FAIL bp_op_count got %0d want %0d", op_count, exp_ops); end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            vectors++; if ({out_valid, out_result, out_flags} !== {1'b1, e[i]}) begin miscompares++; $display("FAIL bp_drain%0d got %h want %h", i, {out_valid, out_result, out_flags}, {1'b1, e[i]}); end
            tick();
        end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_empty got %b want 0 (third entry leaked)", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] q[$];
        logic [3:0] a, b;
        logic       m;
        int         start;
        a = 4'($urandom); b = 4'($urandom); m = 1'($urandom);
        drive_op(a, b, m);
        in_valid = 1'b1; out_ready = 1'b0;
        tick(); count_push(); q.push_back(model(a, b, m));
        start = exp_ops;
        for (int i = 0; i < 10; i++) begin
            a = 4'($urandom); b = 4'($urandom); m = 1'($urandom);
            drive_op(a, b, m);
            in_valid = 1'b1; out_ready = 1'b1;
            vectors++; if ({in_ready, out_valid} !== 2'b11) begin miscompares++; $display("FAIL b2b%0d_count got rdy/vld %b want 11", i, {in_ready, out_valid}); end
            vectors++; if ({out_result, out_flags} !== q[0]) begin miscompares++; $display("FAIL b2b%0d_entry got %h want %h", i, {out_result, out_flags}, q[0]); end
            tick(); count_push();
            void'(q.pop_front());
            q.push_back(model(a, b, m));
        end
        in_valid = 1'b0;
        vectors++; if (int'(op_count) - start !== 10) begin miscompares++; $display("FAIL b2b_op_count got +%0d want +10", int'(op_count) - start); end
        vectors++; if ({out_valid, out_result, out_flags} !== {1'b1, q[0]}) begin miscompares++; $display("FAIL b2b_last got %h want %h", {out_valid, out_result, out_flags}, {1'b1, q[0]}); end
        tick();
        out_ready = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_empty got %b want 0", out_valid); end
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        logic [7:0] last;
        logic       have_last = 1'b0;
        logic [3:0] a, b;
        logic       m, do_push, do_pop;
        for (int i = 0; i < 400; i++) begin
            a = 4'($urandom); b = 4'($urandom); m = 1'($urandom);
            drive_op(a, b, m);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            vectors++; if (in_ready !== (q.size() != DEPTH)) begin miscompares++; $display("FAIL rnd%0d_in_ready got %b want %b", i, in_ready, (q.size() != DEPTH)); end
            vectors++; if (out_valid !== (q.size() != 0)) begin miscompares++; $display("FAIL rnd%0d_out_valid got %b want %b", i, out_valid, (q.size() != 0)); end
            if (q.size() != 0) begin
                vectors++; if ({out_result, out_flags} !== q[0]) begin miscompares++; $display("FAIL rnd%0d_head got %h want %h", i, {out_result, out_flags}, q[0]); end
            end else if (have_last) begin
                vectors++; if ({out_result, out_flags} !== last) begin miscompares++; $display("FAIL rnd%0d_hold got %h want %h", i, {out_result, out_flags}, last); end
            end
            vectors++; if (op_count !== CNT_W'(exp_ops)) begin miscompares++; $display("FAIL rnd%0d_op_count got %0d want %0d", i, op_count, exp_ops); end
            do_push = in_valid && (q.size() != DEPTH);
            do_pop  = out_ready && (q.size() != 0);
            tick();
            if (do_pop) begin last = q.pop_front(); have_last = 1'b1; end
            if (do_push) begin q.push_back(model(a, b, m)); count_push(); end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) tick();
        out_ready = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rnd_drain got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] a, b;
        logic       m;
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_op(4'($urandom), 4'($urandom), 1'($urandom));
            in_valid = 1'b1;
            tick(); count_push();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_ops = 0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
        vectors++; if (op_count !== 8'h00) begin miscompares++; $display("FAIL rstmid_op_count got %0d want 0", op_count); end
        vectors++; if ({out_result, out_flags} !== 8'h00) begin miscompares++; $display("FAIL rstmid_out got %h want 00", {out_result, out_flags}); end
        a = 4'($urandom); b = 4'($urandom); m = 1'($urandom);
        drive_op(a, b, m);
        in_valid = 1'b1;
        tick(); count_push();
        in_valid = 1'b0;
        vectors++; if ({out_valid, out_result, out_flags} !== {1'b1, model(a, b, m)}) begin miscompares++; $display("FAIL rstmid_fresh got %h want %h", {out_valid, out_result, out_flags}, {1'b1, model(a, b, m)}); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rstmid_stale got %b want 0", out_valid); end
    endtask

    task automatic test_op_count_sat();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_ops = 0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            drive_op(4'($urandom), 4'($urandom), 1'($urandom));
            if (i == 255) begin
                vectors++; if (op_count !== CNT_W'(exp_ops)) begin miscompares++; $display("FAIL sat_at255 got %0d want %0d", op_count, exp_ops); end
            end
            tick(); count_push();
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        vectors++; if (op_count !== CNT_W'(exp_ops)) begin miscompares++; $display("FAIL sat_op_count got %0d want %0d", op_count, exp_ops); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_op_count_sat();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
